// File: rtl/ram_read_port_arbiter.sv
// rtl/ram_read_port_arbiter.sv - round-robin arbiter sharing one registered RAM read port between two clients
module ram_read_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_ADDR   = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iEnable,
  input  logic                  iReq0,
  input  logic [ADDR_WIDTH-1:0] iAddr0,
  output logic                  oGnt0,
  output logic                  oValid0,
  input  logic                  iReq1,
  input  logic [ADDR_WIDTH-1:0] iAddr1,
  output logic                  oGnt1,
  output logic                  oValid1,
  output logic [DATA_WIDTH-1:0] oData,
  output logic                  oErr,
  output logic [ADDR_WIDTH-1:0] oRamReadAddress,
  input  logic [DATA_WIDTH-1:0] iRamData
);

  localparam logic [ADDR_WIDTH-1:0] MAX_A = ADDR_WIDTH'(MAX_ADDR);

  // RDx means the RAM output in this cycle belongs to requester x
  typedef enum logic [1:0] {IDLE, RD0, RD1} state_t;

  state_t                  rState, nState;
  logic                    rPtr, nPtr;
  logic                    rErr, nErr;
  logic [ADDR_WIDTH-1:0]   rLastAddr, nLastAddr;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic                    sel_bad;
  logic                    arb_ok;

  // State, priority pointer, error flag and last driven RAM address
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rState    <= IDLE;
      rPtr      <= 1'b0;
      rErr      <= 1'b0;
      rLastAddr <= '0;
    end else begin
      rState    <= nState;
      rPtr      <= nPtr;
      rErr      <= nErr;
      rLastAddr <= nLastAddr;
    end
  end

  // Grant decision, next state and the address presented to the RAM this cycle
  always_comb begin
    oGnt0     = 1'b0;
    oGnt1     = 1'b0;
    nState    = IDLE;
    nPtr      = rPtr;
    nErr      = 1'b0;
    nLastAddr = rLastAddr;
    sel_addr  = '0;
    sel_bad   = 1'b0;
    arb_ok    = iEnable && !Reset;

    // a lone request wins outright; rPtr only breaks ties
    if (arb_ok) begin
      if (iReq0 && (!iReq1 || !rPtr)) begin
        oGnt0 = 1'b1;
      end else if (iReq1) begin
        oGnt1 = 1'b1;
      end
    end

    if (oGnt0) begin
      sel_addr = iAddr0;
      nState   = RD0;
      nPtr     = 1'b1;
    end else if (oGnt1) begin
      sel_addr = iAddr1;
      nState   = RD1;
      nPtr     = 1'b0;
    end

    // out-of-range reads still take a slot but park the RAM on address 0
    if (oGnt0 || oGnt1) begin
      sel_bad   = sel_addr > MAX_A;
      nErr      = sel_bad;
      nLastAddr = sel_bad ? '0 : sel_addr;
    end
  end

  // Without a grant the RAM keeps seeing the previously driven address
  assign oRamReadAddress = nLastAddr;

  // Result side: the registered RAM word is passed through in the cycle after the grant
  assign oValid0 = (rState == RD0);
  assign oValid1 = (rState == RD1);
  assign oErr    = (rState != IDLE) && rErr;
  assign oData   = ((rState != IDLE) && !rErr) ? iRamData : '0;

endmodule

// File: tb/tb_ram_read_port_arbiter.sv
// tb/tb_ram_read_port_arbiter.sv - self-checking bench for ram_read_port_arbiter
module tb_ram_read_port_arbiter;
  localparam int DW   = 16;
  localparam int AW   = 8;
  localparam int MAXA = 8;

  logic          Clock = 1'b0;
  logic          Reset, iEnable, iReq0, iReq1;
  logic [AW-1:0] iAddr0, iAddr1, oRamReadAddress;
  logic          oGnt0, oGnt1, oValid0, oValid1, oErr;
  logic [DW-1:0] oData, iRamData;

  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] mem    [0:255];
  logic [DW-1:0] shadow [0:255];

  int total = 0;
  int bad   = 0;

  // behavioural model state
  int            m_ptr  = 0;
  logic [AW-1:0] m_last = '0;
  bit            p_valid = 0, p_who = 0, p_err = 0;
  logic [DW-1:0] p_data = '0;

  bit g0_seen, g1_seen;

  ram_read_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_ADDR(MAXA)) dut (
    .Clock(Clock), .Reset(Reset), .iEnable(iEnable),
    .iReq0(iReq0), .iAddr0(iAddr0), .oGnt0(oGnt0), .oValid0(oValid0),
    .iReq1(iReq1), .iAddr1(iAddr1), .oGnt1(oGnt1), .oValid1(oValid1),
    .oData(oData), .oErr(oErr), .oRamReadAddress(oRamReadAddress), .iRamData(iRamData)
  );

  always #5 Clock = ~Clock;

  // RAM with registered read; a same-address write in the read cycle returns old data
  always @(posedge Clock) begin
    if (we) mem[waddr] <= wdata;
    iRamData <= mem[oRamReadAddress];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge Clock);
    #2;
  endtask

  task automatic do_reset();
    next_cycle();
    Reset = 1'b1; iReq0 = 1'b0; iReq1 = 1'b0;
    next_cycle();
    Reset = 1'b0;
  endtask

  // Model: each cycle decide the grant from the rules, check it, then check the pending result
  always @(negedge Clock) begin : model
    bit            g0, g1, ev0, ev1, eerr;
    logic [AW-1:0] a, req_a;
    logic [DW-1:0] edata;
    g0 = 0; g1 = 0;
    if (iEnable && !Reset) begin
      if (iReq0 && iReq1) begin
        if (m_ptr == 0) g0 = 1; else g1 = 1;
      end else if (iReq0) g0 = 1;
      else if (iReq1) g1 = 1;
    end
    req_a = g0 ? iAddr0 : iAddr1;
    if (Reset) a = '0;
    else if (g0 || g1) a = (req_a > MAXA) ? '0 : req_a;
    else a = m_last;
    check("m_gnt0", oGnt0, g0);
    check("m_gnt1", oGnt1, g1);
    check("m_addr", oRamReadAddress, a);

    ev0   = !Reset && p_valid && !p_who;
    ev1   = !Reset && p_valid && p_who;
    eerr  = !Reset && p_valid && p_err;
    edata = (!Reset && p_valid && !p_err) ? p_data : '0;
    check("m_valid0", oValid0, ev0);
    check("m_valid1", oValid1, ev1);
    check("m_err", oErr, eerr);
    check("m_data", oData, edata);

    if (Reset) begin
      m_ptr = 0; m_last = '0; p_valid = 0;
    end else begin
      p_valid = g0 || g1;
      if (p_valid) begin
        p_who  = g1;
        p_err  = req_a > MAXA;
        p_data = shadow[a];
        m_last = a;
        m_ptr  = g0 ? 1 : 0;
      end
    end
    if (we) shadow[waddr] = wdata;
  end

  initial begin
    Reset = 1'b1; iEnable = 1'b1; iReq0 = 1'b1; iAddr0 = 8'd3; iReq1 = 1'b0; iAddr1 = '0;
    we = 1'b0; waddr = '0; wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101) ^ 16'h5a00;
    mem[1] = 16'h1111; mem[2] = 16'h2222; mem[3] = 16'hA5A5; mem[5] = 16'h0505;
    mem[6] = 16'h6666; mem[7] = 16'h7777;
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];

    // reset state, with a request already asserted
    @(negedge Clock);
    check("rst_gnt0", oGnt0, 1'b0);
    check("rst_valid", {oValid1, oValid0}, 2'b00);
    check("rst_err", oErr, 1'b0);
    check("rst_addr", oRamReadAddress, 8'd0);

    // single read of address 3
    next_cycle(); Reset = 1'b0;
    @(negedge Clock);
    check("t1_gnt0", oGnt0, 1'b1);
    check("t1_addr", oRamReadAddress, 8'd3);
    next_cycle(); iReq0 = 1'b0;
    @(negedge Clock);
    check("t1_valid0", oValid0, 1'b1);
    check("t1_data", oData, 16'hA5A5);
    check("t1_err", oErr, 1'b0);

    // both requesting: alternating grants, results one cycle later with no gaps
    do_reset();
    iReq0 = 1'b1; iReq1 = 1'b1; iAddr0 = 8'd1; iAddr1 = 8'd2;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clock);
      if (k < 4) check("t2_gnt", {oGnt1, oGnt0}, (k % 2) ? 2'b10 : 2'b01);
      if (k > 0) begin
        check("t2_valid", {oValid1, oValid0}, ((k - 1) % 2) ? 2'b10 : 2'b01);
        check("t2_data", oData, ((k - 1) % 2) ? 16'h2222 : 16'h1111);
      end
      next_cycle();
      if (k == 3) begin iReq0 = 1'b0; iReq1 = 1'b0; end
    end

    // out-of-range address
    iReq1 = 1'b1; iAddr1 = 8'd9;
    @(negedge Clock);
    check("t3_gnt1", oGnt1, 1'b1);
    check("t3_addr", oRamReadAddress, 8'd0);
    next_cycle(); iReq1 = 1'b0;
    @(negedge Clock);
    check("t3_valid1", oValid1, 1'b1);
    check("t3_err", oErr, 1'b1);
    check("t3_data", oData, 16'h0000);

    // reset while a read is in flight
    next_cycle(); iReq0 = 1'b1; iAddr0 = 8'd4;
    @(negedge Clock);
    check("t4_gnt0", oGnt0, 1'b1);
    next_cycle(); iReq0 = 1'b0; Reset = 1'b1;
    @(negedge Clock);
    check("t4_valid", {oValid1, oValid0}, 2'b00);
    next_cycle(); Reset = 1'b0; iReq0 = 1'b1; iReq1 = 1'b1; iAddr0 = 8'd6; iAddr1 = 8'd7;
    @(negedge Clock);
    check("t4_ptr0", {oGnt1, oGnt0}, 2'b01);

    // disable after a grant: result still returned, pointer frozen
    next_cycle();
    @(negedge Clock);
    check("t5_gnt1", {oGnt1, oGnt0}, 2'b10);
    next_cycle(); iEnable = 1'b0;
    @(negedge Clock);
    check("t5_nogntA", {oGnt1, oGnt0}, 2'b00);
    check("t5_valid1", oValid1, 1'b1);
    check("t5_data", oData, 16'h7777);
    next_cycle();
    @(negedge Clock);
    check("t5_nogntB", {oGnt1, oGnt0}, 2'b00);
    check("t5_idle", {oValid1, oValid0}, 2'b00);
    next_cycle(); iEnable = 1'b1;
    @(negedge Clock);
    check("t5_resume", {oGnt1, oGnt0}, 2'b01);
    next_cycle(); iReq0 = 1'b0; iReq1 = 1'b0;
    @(negedge Clock);
    check("t5_data0", oData, 16'h6666);

    // same-cycle write hazard: old data first, new data on the next grant
    next_cycle(); iReq1 = 1'b1; iAddr1 = 8'd5; we = 1'b1; waddr = 8'd5; wdata = 16'h1234;
    @(negedge Clock);
    check("t6_gnt1", oGnt1, 1'b1);
    next_cycle(); we = 1'b0;
    @(negedge Clock);
    check("t6_old", oData, 16'h0505);
    next_cycle(); iReq1 = 1'b0;
    @(negedge Clock);
    check("t6_new", oData, 16'h1234);

    // randomized traffic; requesters hold until granted, occasionally withdraw
    g0_seen = 0; g1_seen = 0;
    for (int n = 0; n < 2000; n++) begin
      next_cycle();
      Reset   = ($urandom_range(0, 99) == 0);
      iEnable = ($urandom_range(0, 9) != 0);
      if (!iReq0 || g0_seen) begin
        iReq0  = ($urandom_range(0, 2) != 0);
        iAddr0 = AW'($urandom_range(0, 12));
      end else if ($urandom_range(0, 15) == 0) iReq0 = 1'b0;
      if (!iReq1 || g1_seen) begin
        iReq1  = ($urandom_range(0, 2) != 0);
        iAddr1 = AW'($urandom_range(0, 12));
      end else if ($urandom_range(0, 15) == 0) iReq1 = 1'b0;
      we    = ($urandom_range(0, 3) == 0);
      waddr = AW'($urandom_range(0, 8));
      wdata = DW'($urandom);
      @(negedge Clock);
      g0_seen = oGnt0;
      g1_seen = oGnt1;
    end

    next_cycle();
    @(negedge Clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
